// File: rtl/act_row_sequencer_pkg.sv
// Shared types and defaults for the activation row sequencer.
package act_row_sequencer_pkg;

    localparam int AR_IF_WIDTH = 16;
    localparam int AR_IDX_W    = 4;
    localparam int AR_ROW_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        FLAG_REQ,
        FLAG_WAIT,
        SERIAL,
        PARALLEL,
        ROW_END,
        DONE
    } state_e;

endpackage

// File: rtl/act_row_sequencer_lsb_index_pick.sv
// Lowest-set-bit picker: presence flag, binary index and one-hot mask.
module act_row_sequencer_lsb_index_pick #(
    parameter int W  = 16,
    parameter int IW = 4
) (
    input  logic [W-1:0]  word_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o,
    output logic [W-1:0]  mask_o
);

    assign found_o = |word_i;
    assign mask_o  = word_i & (~word_i + W'(1));

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (word_i[i]) idx_o = IW'(i);
        end
    end

endmodule

// File: rtl/act_row_sequencer.sv
// Walks an activation tile row by row, offering flagged columns
// to the PE array over a valid/ready handshake.
module act_row_sequencer
    import act_row_sequencer_pkg::*;
#(
    parameter int IF_WIDTH = AR_IF_WIDTH,
    parameter int IDX_W    = AR_IDX_W,
    parameter int ROW_W    = AR_ROW_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_mode,
    input  logic [ROW_W-1:0]    cfg_num_rows,
    input  logic                start,
    output logic                flag_rd_req,
    input  logic [IF_WIDTH-1:0] flag_rd_data,
    output logic [IF_WIDTH-1:0] col_rd_req,
    output logic                col_rd_en,
    output logic [IDX_W-1:0]    act_idx,
    output logic                act_valid,
    input  logic                act_ready,
    output logic [IDX_W:0]      row_val_num,
    output logic                row_done,
    output logic                zero_row,
    output logic                busy,
    output logic                done
);

    function automatic logic [IDX_W:0] popcnt(input logic [IF_WIDTH-1:0] w);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < IF_WIDTH; i++) begin
            c = c + (IDX_W+1)'(w[i]);
        end
        return c;
    endfunction

    state_e              state_q, state_d;
    logic [IF_WIDTH-1:0] pending_q, pending_d;
    logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
    logic [ROW_W-1:0]    num_rows_q, num_rows_d;
    logic                mode_q, mode_d;
    logic [IDX_W:0]      rvn_q, rvn_d;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [IF_WIDTH-1:0] pick_mask;
    logic [IF_WIDTH-1:0] pending_left;

    act_row_sequencer_lsb_index_pick #(
        .W  (IF_WIDTH),
        .IW (IDX_W)
    ) u_pick (
        .word_i  (pending_q),
        .found_o (pick_found),
        .idx_o   (pick_idx),
        .mask_o  (pick_mask)
    );

    assign pending_left = pending_q & ~pick_mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            row_cnt_q  <= '0;
            num_rows_q <= '0;
            mode_q     <= 1'b0;
            rvn_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            row_cnt_q  <= row_cnt_d;
            num_rows_q <= num_rows_d;
            mode_q     <= mode_d;
            rvn_q      <= rvn_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        row_cnt_d   = row_cnt_q;
        num_rows_d  = num_rows_q;
        mode_d      = mode_q;
        rvn_d       = rvn_q;
        flag_rd_req = 1'b0;
        col_rd_req  = '0;
        act_idx     = '0;
        act_valid   = 1'b0;
        row_done    = 1'b0;
        zero_row    = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_num_rows == '0) begin
                        state_d = DONE;
                    end else begin
                        mode_d     = cfg_mode;
                        num_rows_d = cfg_num_rows;
                        row_cnt_d  = '0;
                        state_d    = FLAG_REQ;
                    end
                end
            end
            FLAG_REQ: begin
                flag_rd_req = 1'b1;
                state_d     = FLAG_WAIT;
            end
            FLAG_WAIT: begin
                pending_d = flag_rd_data;
                rvn_d     = popcnt(flag_rd_data);
                if (flag_rd_data == '0) begin
                    zero_row = 1'b1;
                    state_d  = ROW_END;
                end else if (mode_q) begin
                    state_d = PARALLEL;
                end else begin
                    state_d = SERIAL;
                end
            end
            SERIAL: begin
                act_valid  = pick_found;
                act_idx    = pick_idx;
                col_rd_req = pick_mask;
                if (act_ready || !pick_found) begin
                    pending_d = pending_left;
                    if (pending_left == '0) state_d = ROW_END;
                end
            end
            PARALLEL: begin
                act_valid  = 1'b1;
                col_rd_req = pending_q;
                if (act_ready) state_d = ROW_END;
            end
            ROW_END: begin
                row_done  = 1'b1;
                row_cnt_d = row_cnt_q + ROW_W'(1);
                if (row_cnt_d == num_rows_q) begin
                    state_d = DONE;
                end else begin
                    state_d = FLAG_REQ;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign col_rd_en   = act_valid;
    assign row_val_num = rvn_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_act_row_sequencer.sv
// Scoreboard bench for act_row_sequencer: stimulus queues expected
// events, a negedge monitor pops and compares them as they appear.
module tb_act_row_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_mode;
    logic [7:0]  cfg_num_rows;
    logic        start;
    logic        flag_rd_req;
    logic [15:0] flag_rd_data;
    logic [15:0] col_rd_req;
    logic        col_rd_en;
    logic [3:0]  act_idx;
    logic        act_valid;
    logic        act_ready;
    logic [4:0]  row_val_num;
    logic        row_done;
    logic        zero_row;
    logic        busy;
    logic        done;

    act_row_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_mode     (cfg_mode),
        .cfg_num_rows (cfg_num_rows),
        .start        (start),
        .flag_rd_req  (flag_rd_req),
        .flag_rd_data (flag_rd_data),
        .col_rd_req   (col_rd_req),
        .col_rd_en    (col_rd_en),
        .act_idx      (act_idx),
        .act_valid    (act_valid),
        .act_ready    (act_ready),
        .row_val_num  (row_val_num),
        .row_done     (row_done),
        .zero_row     (zero_row),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         rel;
        logic [3:0] idx;
        logic [15:0] req;
        logic [4:0] rvn;
    } beat_t;

    typedef struct {
        int         rel;
        logic [4:0] rvn;
    } row_t;

    beat_t eb[$];
    row_t  er[$];
    int    efr[$];
    int    ez[$];
    int    ed[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rd_ptr = 0;
    logic [15:0] flag_mem [0:7];

    task automatic chk(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Flag RAM model: one-cycle read latency, address restarts when idle.
    always @(posedge clk) begin
        if (flag_rd_req) begin
            flag_rd_data <= (rd_ptr < 8) ? flag_mem[rd_ptr] : 16'h0000;
            rd_ptr = rd_ptr + 1;
        end else if (!busy) begin
            rd_ptr = 0;
        end
    end

    bit          stall_prev = 1'b0;
    logic [3:0]  p_idx;
    logic [15:0] p_req;

    always @(negedge clk) begin
        int    rel;
        beat_t b;
        row_t  r;
        int    e;
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            if (start && !busy) start_cyc = cyc;
            rel = cyc - start_cyc;
            if (stall_prev) begin
                chk(act_valid && act_idx == p_idx && col_rd_req == p_req,
                    "hold_stable", {act_valid, act_idx, col_rd_req},
                    {1'b1, p_idx, p_req});
            end
            stall_prev = act_valid && !act_ready;
            p_idx = act_idx;
            p_req = col_rd_req;
            if (act_valid && act_ready) begin
                if (eb.size() == 0) begin
                    chk(0, "unexpected_beat", {act_idx, col_rd_req}, 0);
                end else begin
                    b = eb.pop_front();
                    chk(act_idx == b.idx && col_rd_req == b.req &&
                        row_val_num == b.rvn && col_rd_en,
                        "beat", {col_rd_en, row_val_num, act_idx, col_rd_req},
                        {1'b1, b.rvn, b.idx, b.req});
                    if (b.rel >= 0) chk(rel == b.rel, "beat_cycle", rel, b.rel);
                end
            end
            if (flag_rd_req) begin
                if (efr.size() == 0) begin
                    chk(0, "unexpected_flag_rd_req", rel, 0);
                end else begin
                    e = efr.pop_front();
                    if (e >= 0) chk(rel == e, "flag_rd_cycle", rel, e);
                end
            end
            if (zero_row) begin
                if (ez.size() == 0) begin
                    chk(0, "unexpected_zero_row", rel, 0);
                end else begin
                    e = ez.pop_front();
                    if (e >= 0) chk(rel == e, "zero_row_cycle", rel, e);
                end
            end
            if (row_done) begin
                if (er.size() == 0) begin
                    chk(0, "unexpected_row_done", rel, 0);
                end else begin
                    r = er.pop_front();
                    chk(row_val_num == r.rvn, "row_val_num", row_val_num, r.rvn);
                    if (r.rel >= 0) chk(rel == r.rel, "row_done_cycle", rel, r.rel);
                end
            end
            if (done) begin
                if (ed.size() == 0) begin
                    chk(0, "unexpected_done", rel, 0);
                end else begin
                    e = ed.pop_front();
                    if (e >= 0) chk(rel == e, "done_cycle", rel, e);
                end
            end
        end
    end

    function automatic bit q_empty();
        return eb.size() == 0 && er.size() == 0 && efr.size() == 0 &&
               ez.size() == 0 && ed.size() == 0;
    endfunction

    task automatic push_beat(input int rel, input logic [3:0] idx,
                             input logic [15:0] req, input logic [4:0] rvn);
        beat_t b;
        b.rel = rel; b.idx = idx; b.req = req; b.rvn = rvn;
        eb.push_back(b);
    endtask

    task automatic push_row(input int rel, input logic [4:0] rvn);
        row_t r;
        r.rel = rel; r.rvn = rvn;
        er.push_back(r);
    endtask

    task automatic start_tile(input logic m, input logic [7:0] n);
        @(posedge clk); #1;
        cfg_mode = m;
        cfg_num_rows = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (!busy && q_empty()) break;
        end
        chk(!busy && q_empty(), nm, {busy, 8'(eb.size()), 8'(er.size()),
            8'(ed.size())}, 0);
    endtask

    function automatic logic [31:0] all_outs();
        return {5'(0), flag_rd_req, col_rd_en, act_valid, act_idx,
                row_val_num, row_done, zero_row, busy, done} ^
               {16'h0, col_rd_req};
    endfunction

    initial begin
        reset = 1'b0;
        cfg_mode = 1'b0;
        cfg_num_rows = 8'd0;
        start = 1'b0;
        act_ready = 1'b1;
        flag_rd_data = 16'h0;
        for (int i = 0; i < 8; i++) flag_mem[i] = 16'h0;
        #1;
        chk(all_outs() == 0 && col_rd_req == 0, "reset_outputs", all_outs(), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // serial row, flags 0x8421
        flag_mem[0] = 16'h8421;
        efr.push_back(1);
        push_beat(3, 4'd0, 16'h0001, 5'd4);
        push_beat(4, 4'd5, 16'h0020, 5'd4);
        push_beat(5, 4'd10, 16'h0400, 5'd4);
        push_beat(6, 4'd15, 16'h8000, 5'd4);
        push_row(7, 5'd4);
        ed.push_back(8);
        start_tile(1'b0, 8'd1);
        wait_idle("serial_8421_drain", 100);

        // parallel, three rows including a zero row and a full row
        flag_mem[0] = 16'h00FF;
        flag_mem[1] = 16'h0000;
        flag_mem[2] = 16'hFFFF;
        efr.push_back(1); efr.push_back(5); efr.push_back(8);
        push_beat(3, 4'd0, 16'h00FF, 5'd8);
        push_beat(10, 4'd0, 16'hFFFF, 5'd16);
        ez.push_back(6);
        push_row(4, 5'd8);
        push_row(7, 5'd0);
        push_row(11, 5'd16);
        ed.push_back(12);
        start_tile(1'b1, 8'd3);
        wait_idle("parallel_drain", 100);

        // backpressure on a serial row
        flag_mem[0] = 16'h0003;
        act_ready = 1'b0;
        efr.push_back(1);
        push_beat(8, 4'd0, 16'h0001, 5'd2);
        push_beat(9, 4'd1, 16'h0002, 5'd2);
        push_row(10, 5'd2);
        ed.push_back(11);
        start_tile(1'b0, 8'd1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                chk(act_valid && act_idx == 4'd0 && col_rd_req == 16'h0001,
                    "stall_hold", {act_valid, act_idx, col_rd_req},
                    {1'b1, 4'd0, 16'h0001});
            end
        end
        @(posedge clk); #1 act_ready = 1'b1;
        wait_idle("backpressure_drain", 100);

        // zero-row tile count
        ed.push_back(-1);
        start_tile(1'b0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk(ed.size() == 0, "zero_cfg_done_by_2", 32'(ed.size()), 0);
        wait_idle("zero_cfg_drain", 20);

        // second start mid-tile with different cfg is ignored
        flag_mem[0] = 16'h0001;
        flag_mem[1] = 16'h0002;
        efr.push_back(1); efr.push_back(5);
        push_beat(3, 4'd0, 16'h0001, 5'd1);
        push_beat(7, 4'd1, 16'h0002, 5'd1);
        push_row(4, 5'd1);
        push_row(8, 5'd1);
        ed.push_back(9);
        start_tile(1'b0, 8'd2);
        @(posedge clk);
        @(posedge clk); #1;
        cfg_mode = 1'b1;
        cfg_num_rows = 8'd5;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle("busy_start_drain", 100);

        // maximum row count, all rows empty
        for (int i = 0; i < 8; i++) flag_mem[i] = 16'h0;
        for (int r = 0; r < 255; r++) begin
            efr.push_back(1 + 3 * r);
            ez.push_back(2 + 3 * r);
            push_row(3 + 3 * r, 5'd0);
        end
        ed.push_back(766);
        start_tile(1'b0, 8'd255);
        wait_idle("max_rows_drain", 1000);

        // asynchronous reset in the middle of a serial row
        flag_mem[0] = 16'h00F0;
        flag_mem[1] = 16'h0003;
        act_ready = 1'b0;
        efr.push_back(1);
        start_tile(1'b0, 8'd2);
        repeat (4) @(negedge clk);
        chk(act_valid && act_idx == 4'd4 && col_rd_req == 16'h0010 &&
            row_val_num == 5'd4, "pre_reset_serial",
            {act_valid, row_val_num, act_idx, col_rd_req},
            {1'b1, 5'd4, 4'd4, 16'h0010});
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk(all_outs() == 0 && col_rd_req == 0, "async_reset_outputs",
            all_outs(), 0);
        chk(q_empty(), "reset_queue_state", 32'(efr.size()), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        act_ready = 1'b1;
        efr.push_back(1);
        push_beat(3, 4'd4, 16'h0010, 5'd4);
        push_beat(4, 4'd5, 16'h0020, 5'd4);
        push_beat(5, 4'd6, 16'h0040, 5'd4);
        push_beat(6, 4'd7, 16'h0080, 5'd4);
        push_row(7, 5'd4);
        ed.push_back(8);
        start_tile(1'b0, 8'd1);
        wait_idle("post_reset_drain", 100);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
